scan_reg_bank: RTL and testbench



---
 rtl/scan_pkg.sv | 37 +++
 rtl/scan_chain_seg.sv | 57 +++++
 rtl/scan_reg_bank.sv | 105 ++++++++++
 tb/tb_scan_reg_bank.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scan_pkg
// Description : Shared types and helpers for the scan register bank. It holds
//               the per-cycle operating mode and the functions that size a
//               chain and its shift counter.
// Revision    : 1.0 - initial release
// ============================================================================
package scan_pkg;

    // Operating mode, decoded once per cycle from the control inputs.
    typedef enum logic [2:0] {
        HOLD    = 3'd0,
        CAPTURE = 3'd1,
        SHIFT   = 3'd2,
        SET     = 3'd3,
        CLR     = 3'd4
    } scan_mode_e;

    // Length of one chain. A bad CHAINS value is trapped at elaboration;
    // the guard only keeps this division from faulting before that check.
    function automatic int chain_len(input int width, input int chains);
        if (chains < 1) begin
            return 1;
        end
        return width / chains;
    endfunction

    // Bits needed to hold a count from 0 to l inclusive.
    function automatic int cnt_width(input int l);
        int w;
        w = $clog2(l + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : scan_pkg
`default_nettype wire

// File: rtl/scan_chain_seg.sv
`default_nettype none
// ============================================================================
// Module      : scan_chain_seg
// Description : One L-bit segment of the scan register bank. Applies the
//               decoded mode to its slice: reset, clear, set, shift from SI
//               toward the MSB, capture of D, or hold.
// Ports       : CLK  - rising-edge clock
//               RST  - synchronous active-high reset, loads RESET_VAL
//               mode - decoded operating mode for this cycle
//               D    - functional data slice
//               SI   - scan-in bit entering bit 0
//               Q    - segment state
//               SO   - scan-out, the MSB of the segment
// Revision    : 1.0 - initial release
// ============================================================================
module scan_chain_seg
    import scan_pkg::*;
#(
    parameter int             L         = 4,
    parameter logic [L-1:0]   RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  scan_mode_e       mode,
    input  logic [L-1:0]     D,
    input  logic             SI,
    output logic [L-1:0]     Q,
    output logic             SO
);

    logic [L-1:0] shift_next;

    // A one-bit chain has no lower bits to move up, so it simply loads SI.
    if (L == 1) begin : g_len_one
        assign shift_next = SI;
    end else begin : g_len_multi
        assign shift_next = {Q[L-2:0], SI};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            Q <= RESET_VAL;
        end else begin
            case (mode)
                CLR:     Q <= '0;
                SET:     Q <= '1;
                SHIFT:   Q <= shift_next;
                CAPTURE: Q <= D;
                default: Q <= Q;
            endcase
        end
    end

    assign SO = Q[L-1];

endmodule : scan_chain_seg
`default_nettype wire

// File: rtl/scan_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : scan_reg_bank
// Description : WIDTH-bit scan-testable register bank split into CHAINS
//               independent scan chains of length L = WIDTH/CHAINS. Supports
//               functional capture, synchronous set/clear and parallel scan
//               shift, with a saturating shift counter and scan_done flag.
// Ports       : CLK       - rising-edge clock
//               RST       - synchronous active-high reset
//               EN        - functional capture enable
//               D         - functional data
//               SE        - scan enable, 1 = shift
//               SI        - scan-in, one bit per chain
//               SETB      - synchronous set, active-low
//               CLRB      - synchronous clear, active-low (wins over SETB)
//               Q / QN    - register state and its complement
//               SO        - scan-out, MSB of each chain
//               scan_done - high while the shift count equals L
// Revision    : 1.0 - initial release
// ============================================================================
module scan_reg_bank
    import scan_pkg::*;
#(
    parameter int                 WIDTH     = 8,
    parameter int                 CHAINS    = 2,
    parameter logic [WIDTH-1:0]   RESET_VAL = 8'hA5
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                EN,
    input  logic [WIDTH-1:0]    D,
    input  logic                SE,
    input  logic [CHAINS-1:0]   SI,
    input  logic                SETB,
    input  logic                CLRB,
    output logic [WIDTH-1:0]    Q,
    output logic [WIDTH-1:0]    QN,
    output logic [CHAINS-1:0]   SO,
    output logic                scan_done
);

    localparam int L  = chain_len(WIDTH, CHAINS);
    localparam int CW = cnt_width(L);
    localparam logic [CW-1:0] CNT_MAX = CW'(L);

    if ((WIDTH < 1) || (CHAINS < 1) || ((WIDTH % CHAINS) != 0)) begin : g_param_check
        $fatal(1, "scan_reg_bank: WIDTH must be >= 1 and a multiple of CHAINS >= 1");
    end

    scan_mode_e      mode;
    logic [CW-1:0]   shift_cnt;
    logic [CW-1:0]   cnt_next;

    // Priority: clear, set, shift, capture, hold. Reset is applied in the
    // registers themselves so it overrides every mode.
    always_comb begin
        mode = HOLD;
        if (!CLRB) begin
            mode = CLR;
        end else if (!SETB) begin
            mode = SET;
        end else if (SE) begin
            mode = SHIFT;
        end else if (EN) begin
            mode = CAPTURE;
        end
    end

    // Count shift edges up to L and hold there; any non-shift edge restarts.
    always_comb begin
        cnt_next = '0;
        if (mode == SHIFT) begin
            cnt_next = (shift_cnt == CNT_MAX) ? shift_cnt : shift_cnt + CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            shift_cnt <= '0;
            scan_done <= 1'b0;
        end else begin
            shift_cnt <= cnt_next;
            scan_done <= (cnt_next == CNT_MAX);
        end
    end

    for (genvar c = 0; c < CHAINS; c++) begin : g_chain
        scan_chain_seg #(
            .L         (L),
            .RESET_VAL (RESET_VAL[c*L +: L])
        ) u_seg (
            .CLK  (CLK),
            .RST  (RST),
            .mode (mode),
            .D    (D[c*L +: L]),
            .SI   (SI[c]),
            .Q    (Q[c*L +: L]),
            .SO   (SO[c])
        );
    end

    assign QN = ~Q;

endmodule : scan_reg_bank
`default_nettype wire

// File: tb/tb_scan_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_scan_reg_bank
// Description : Scoreboard bench for scan_reg_bank. Instance A uses the
//               default 8-bit/2-chain configuration, instance B uses 4 chains
//               of length 2. Each stimulus edge pushes its hand-computed
//               expectation; a monitor pops and compares after each edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_reg_bank;

    typedef struct {
        int          sel;
        logic [7:0]  q;
        logic [3:0]  so;
        logic        done;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: WIDTH=8, CHAINS=2, L=4
    logic       rst_a = 0, en_a = 0, se_a = 0, setb_a = 1, clrb_a = 1;
    logic [7:0] d_a = '0;
    logic [1:0] si_a = '0;
    logic [7:0] q_a, qn_a;
    logic [1:0] so_a;
    logic       done_a;

    scan_reg_bank #(.WIDTH(8), .CHAINS(2), .RESET_VAL(8'hA5)) u_dut_a (
        .CLK(clk), .RST(rst_a), .EN(en_a), .D(d_a), .SE(se_a), .SI(si_a),
        .SETB(setb_a), .CLRB(clrb_a), .Q(q_a), .QN(qn_a), .SO(so_a),
        .scan_done(done_a)
    );

    // Instance B: WIDTH=8, CHAINS=4, L=2
    logic       rst_b = 0, en_b = 0, se_b = 0, setb_b = 1, clrb_b = 1;
    logic [7:0] d_b = '0;
    logic [3:0] si_b = '0;
    logic [7:0] q_b, qn_b;
    logic [3:0] so_b;
    logic       done_b;

    scan_reg_bank #(.WIDTH(8), .CHAINS(4), .RESET_VAL(8'hA5)) u_dut_b (
        .CLK(clk), .RST(rst_b), .EN(en_b), .D(d_b), .SE(se_b), .SI(si_b),
        .SETB(setb_b), .CLRB(clrb_b), .Q(q_b), .QN(qn_b), .SO(so_b),
        .scan_done(done_b)
    );

    task automatic cmp(input string name, input string field,
                       input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=%h required=%h", name, field, act, req);
        end
    endtask

    // Drive one edge on A and queue its expected result.
    task automatic step_a(input logic rst, input logic en, input logic [7:0] d,
                          input logic se, input logic [1:0] si,
                          input logic setb, input logic clrb,
                          input logic [7:0] eq, input logic edone, input string name);
        exp_t e;
        @(negedge clk);
        rst_a = rst; en_a = en; d_a = d; se_a = se; si_a = si;
        setb_a = setb; clrb_a = clrb;
        e.sel = 0; e.q = eq; e.so = {2'b00, eq[7], eq[3]}; e.done = edone; e.name = name;
        sb.push_back(e);
    endtask

    task automatic step_b(input logic rst, input logic se, input logic [3:0] si,
                          input logic [7:0] eq, input logic edone, input string name);
        exp_t e;
        @(negedge clk);
        rst_b = rst; en_b = 1'b0; d_b = 8'h00; se_b = se; si_b = si;
        setb_b = 1'b1; clrb_b = 1'b1;
        e.sel = 1; e.q = eq; e.so = {eq[7], eq[5], eq[3], eq[1]}; e.done = edone; e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: one queued expectation per clock edge, checked just after it.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                if (e.sel == 0) begin
                    cmp(e.name, "Q",    q_a,                 e.q);
                    cmp(e.name, "QN",   qn_a,                ~e.q);
                    cmp(e.name, "SO",   {6'b0, so_a},        {4'b0, e.so});
                    cmp(e.name, "done", {7'b0, done_a},      {7'b0, e.done});
                end else begin
                    cmp(e.name, "Q",    q_b,                 e.q);
                    cmp(e.name, "QN",   qn_b,                ~e.q);
                    cmp(e.name, "SO",   {4'b0, so_b},        {4'b0, e.so});
                    cmp(e.name, "done", {7'b0, done_b},      {7'b0, e.done});
                end
            end
        end
    end

    initial begin
        //      rst en  d      se si     setb clrb exp_q  done name
        step_a(1, 0, 8'h00, 0, 2'b00, 1, 1, 8'hA5, 0, "reset");
        step_a(0, 1, 8'h3C, 0, 2'b00, 1, 1, 8'h3C, 0, "capture");
        step_a(0, 0, 8'hFF, 0, 2'b00, 1, 1, 8'h3C, 0, "hold");
        step_a(0, 0, 8'h00, 0, 2'b00, 1, 0, 8'h00, 0, "clear");
        step_a(0, 0, 8'h00, 1, 2'b01, 1, 1, 8'h01, 0, "shift1");
        step_a(0, 0, 8'h00, 1, 2'b01, 1, 1, 8'h03, 0, "shift2");
        step_a(0, 0, 8'h00, 1, 2'b01, 1, 1, 8'h07, 0, "shift3");
        step_a(0, 0, 8'h00, 1, 2'b01, 1, 1, 8'h0F, 1, "shift4_done");
        step_a(0, 0, 8'h00, 1, 2'b01, 1, 1, 8'h0F, 1, "shift5_sat");
        step_a(0, 0, 8'h00, 0, 2'b01, 1, 1, 8'h0F, 0, "se_low");
        step_a(0, 1, 8'hAA, 1, 2'b11, 0, 0, 8'h00, 0, "prio_clr");
        step_a(0, 1, 8'hAA, 1, 2'b11, 0, 1, 8'hFF, 0, "prio_set");
        // Count restarted by the set: done only on the 4th following shift.
        step_a(0, 0, 8'h00, 1, 2'b00, 1, 1, 8'hEE, 0, "post_set1");
        step_a(0, 0, 8'h00, 1, 2'b00, 1, 1, 8'hCC, 0, "post_set2");
        step_a(0, 0, 8'h00, 1, 2'b00, 1, 1, 8'h88, 0, "post_set3");
        step_a(0, 0, 8'h00, 1, 2'b00, 1, 1, 8'h00, 1, "post_set4");
        step_a(0, 0, 8'h00, 0, 2'b00, 1, 1, 8'h00, 0, "idle");
        step_a(0, 0, 8'h00, 1, 2'b01, 1, 1, 8'h01, 0, "mid1");
        step_a(0, 0, 8'h00, 1, 2'b01, 1, 1, 8'h03, 0, "mid2");
        step_a(1, 0, 8'h00, 1, 2'b01, 1, 1, 8'hA5, 0, "rst_mid");
        // EN is asserted alongside SE here and must be ignored.
        step_a(0, 1, 8'h55, 1, 2'b00, 1, 1, 8'h4A, 0, "re1_en_ign");
        step_a(0, 1, 8'h55, 1, 2'b00, 1, 1, 8'h84, 0, "re2");
        step_a(0, 0, 8'h00, 1, 2'b00, 1, 1, 8'h08, 0, "re3");
        step_a(0, 0, 8'h00, 1, 2'b00, 1, 1, 8'h00, 1, "re4_done");
        step_a(0, 0, 8'h00, 0, 2'b00, 1, 1, 8'h00, 0, "a_park");

        //      rst se si      exp_q  done name
        step_b(1, 0, 4'b0000, 8'hA5, 0, "b_reset");
        step_b(0, 1, 4'b1010, 8'h4E, 0, "b_shift1");
        step_b(0, 1, 4'b1010, 8'hCC, 1, "b_shift2");
        step_b(0, 0, 4'b1010, 8'hCC, 0, "b_se_low");

        // Allow the monitor to drain, with a bounded wait.
        begin
            int budget = 20;
            while (sb.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            #2;
            if (sb.size() > 0) begin
                checks++;
                errors++;
                $display("FAIL drain actual=%0d pending required=0", sb.size());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_scan_reg_bank
`default_nettype wire
